rvga_mem_arbiter: RTL and testbench
===================================

Name: rvga_mem_arbiter

Overview:
- Shares one single-ported backing memory between the core's instruction-fetch port and data port.
- Sits between rvga_top's imem/dmem interfaces and the external memory.
- Default priority goes to the data port, because the memory stage is older than fetch. A starvation counter guarantees that fetch is eventually served.
- Transactions are non-overlapped: exactly one memory access is outstanding at a time.

Parameters:
- WORD_W, 32, width of address and data (rvga_word).
- STARVE_LIMIT, 4, maximum number of consecutive dmem grants while an imem request is pending; the next grant is then forced to imem. Range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous assert, active-low.
- imem_r_v_i  in  1  instruction read request; held until imem_resp_v_o.
- imem_addr_i  in  WORD_W  instruction address.
- imem_data_o  out  WORD_W  instruction read data; valid with imem_resp_v_o.
- imem_resp_v_o  out  1  one-cycle instruction response pulse.
- dmem_r_v_i  in  1  data read request; held until dmem_resp_v_o.
- dmem_w_v_i  in  1  data write request; held until dmem_resp_v_o.
- dmem_addr_i  in  WORD_W  data address.
- dmem_data_i  in  WORD_W  store data.
- dmem_data_o  out  WORD_W  load data; valid with dmem_resp_v_o.
- dmem_resp_v_o  out  1  one-cycle data response pulse.
- mem_r_v_o  out  1  memory read strobe; held until mem_resp_v_i.
- mem_w_v_o  out  1  memory write strobe; held until mem_resp_v_i.
- mem_addr_o  out  WORD_W  memory address.
- mem_data_o  out  WORD_W  memory write data.
- mem_data_i  in  WORD_W  memory read data.
- mem_resp_v_i  in  1  memory completion, one cycle.

Behaviour:
- FSM states: IDLE, IBUSY, DBUSY, GAP. Reset (rst_i=0, asynchronous) forces:
  - state=IDLE, starvation counter=0;
  - mem_r_v_o=0, mem_w_v_o=0, mem_addr_o=0, mem_data_o=0;
  - both resp outputs 0.
- IDLE arbitration, evaluated each cycle:
  - dreq = dmem_r_v_i | dmem_w_v_i.
  - If dreq and !(imem_r_v_i and cnt==STARVE_LIMIT): go to DBUSY.
  - Else if imem_r_v_i: go to IBUSY.
  - Else: stay in IDLE.
- Latching on entry to DBUSY, registered from the IDLE-cycle inputs:
  - mem_addr_o and mem_data_o are captured.
  - mem_w_v_o=dmem_w_v_i; mem_r_v_o=!dmem_w_v_i. If read and write are both asserted, the write wins and a simulation assertion fires.
- Latching on entry to IBUSY:
  - mem_addr_o=imem_addr_i, mem_r_v_o=1, mem_w_v_o=0.
  - mem_data_o holds its last value.
- In IBUSY/DBUSY, the strobes, address and data are held stable until mem_resp_v_i. There is no timeout.
- Responses (combinational, during the mem_resp_v_i cycle):
  - In IBUSY: imem_resp_v_o=1, imem_data_o=mem_data_i.
  - In DBUSY: dmem_resp_v_o=1, dmem_data_o=mem_data_i.
  - The data outputs carry mem_data_i in all other cycles; only the resp pulses are meaningful.
- Write completion: dmem_resp_v_o pulses; dmem_data_o is don't-care.
- Mid-transaction changes: a granted transaction always completes even if the requester drops its request. The resp still pulses.
- Exit from BUSY: on mem_resp_v_i, the strobes clear on the next edge and the state goes to GAP.
  - GAP lasts exactly one cycle, then returns to IDLE.
  - GAP prevents a still-asserted request from being reissued in the cycle the pipeline advances.
  - Throughput: one access per 3 cycles minimum (IDLE, BUSY with same-cycle resp, GAP).
- Starvation counter (4 bits, saturating at STARVE_LIMIT):
  - +1 on each DBUSY grant made while imem_r_v_i=1.
  - Cleared on every IBUSY grant.
  - Cleared in IDLE when imem_r_v_i=0.
- mem_resp_v_i outside IBUSY/DBUSY is ignored; no resp pulses.

Test Plan:
- Reset mid-DBUSY (rst_i low during a pending write to 0x100): all strobes and resps drop immediately; after release the state is IDLE and there is no response pulse.
- Imem only, addr 0x40, mem responds 2 cycles after the strobe with 0x00500093: mem_r_v_o high for 3 cycles, imem_resp_v_o one pulse with imem_data_o=0x00500093, and the next grant no earlier than 2 cycles later.
- Simultaneous imem read 0x44 and dmem read 0x200: dmem is granted first (mem_addr_o=0x200) and imem is served after GAP+IDLE; with a same-cycle resp the imem strobe appears 3 cycles after the dmem strobe.
- Dmem write 0x300 with data 0xDEADBEEF: mem_w_v_o=1, mem_r_v_o=0, data held until resp, dmem_resp_v_o pulses once.
- Starvation with STARVE_LIMIT=4, dmem and imem requests held continuously: exactly 4 dmem grants, then 1 imem grant, then the pattern repeats.
- Requester drops dmem_r_v_i one cycle after grant: the memory transaction still completes with exactly one dmem_resp_v_o, and a spurious mem_resp_v_i in IDLE produces no pulse.

Source files
------------

// File: rtl/rvga_mem_arbiter.sv
// rvga_mem_arbiter: shares one single-ported memory between the instruction-fetch
// and data ports. Data wins by default; a starvation counter forces a fetch grant
// after STARVE_LIMIT consecutive data grants made while fetch was waiting.
// Exactly one memory access is outstanding at a time.
module rvga_mem_arbiter #(
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              imem_r_v_i,
    input  logic [WORD_W-1:0] imem_addr_i,
    output logic [WORD_W-1:0] imem_data_o,
    output logic              imem_resp_v_o,

    input  logic              dmem_r_v_i,
    input  logic              dmem_w_v_i,
    input  logic [WORD_W-1:0] dmem_addr_i,
    input  logic [WORD_W-1:0] dmem_data_i,
    output logic [WORD_W-1:0] dmem_data_o,
    output logic              dmem_resp_v_o,

    output logic              mem_r_v_o,
    output logic              mem_w_v_o,
    output logic [WORD_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_data_o,
    input  logic [WORD_W-1:0] mem_data_i,
    input  logic              mem_resp_v_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IBUSY = 2'd1;
    localparam logic [1:0] ST_DBUSY = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_mem_r_v;
    logic              r_mem_w_v;
    logic [WORD_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_mem_data;

    logic [1:0]        w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic              w_mem_r_v_nxt;
    logic              w_mem_w_v_nxt;
    logic [WORD_W-1:0] w_mem_addr_nxt;
    logic [WORD_W-1:0] w_mem_data_nxt;

    logic              w_dreq;
    logic              w_starved;
    logic              w_dgrant;

    assign w_dreq    = dmem_r_v_i | dmem_w_v_i;
    assign w_starved = imem_r_v_i && (r_cnt == LIMIT);
    assign w_dgrant  = (r_state == ST_IDLE) && w_dreq && !w_starved;

    // Arbitration, request latching and busy/gap sequencing.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_mem_r_v_nxt  = r_mem_r_v;
        w_mem_w_v_nxt  = r_mem_w_v;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_data_nxt = r_mem_data;
        case (r_state)
            ST_IDLE: begin
                if (!imem_r_v_i) begin
                    w_cnt_nxt = 4'd0;
                end
                if (w_dgrant) begin
                    w_state_nxt    = ST_DBUSY;
                    w_mem_addr_nxt = dmem_addr_i;
                    w_mem_data_nxt = dmem_data_i;
                    // Write takes precedence if both strobes are up.
                    w_mem_w_v_nxt  = dmem_w_v_i;
                    w_mem_r_v_nxt  = !dmem_w_v_i;
                    if (imem_r_v_i && (r_cnt != LIMIT)) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end else if (imem_r_v_i) begin
                    w_state_nxt    = ST_IBUSY;
                    w_mem_addr_nxt = imem_addr_i;
                    w_mem_r_v_nxt  = 1'b1;
                    w_mem_w_v_nxt  = 1'b0;
                    w_cnt_nxt      = 4'd0;
                end
            end
            ST_IBUSY, ST_DBUSY: begin
                if (mem_resp_v_i) begin
                    w_state_nxt   = ST_GAP;
                    w_mem_r_v_nxt = 1'b0;
                    w_mem_w_v_nxt = 1'b0;
                end
            end
            ST_GAP: begin
                // One dead cycle so a still-held request is not reissued.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and memory-side registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_mem_r_v  <= 1'b0;
            r_mem_w_v  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mem_r_v  <= w_mem_r_v_nxt;
            r_mem_w_v  <= w_mem_w_v_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_data <= w_mem_data_nxt;
        end
    end

    // Flag a data request carrying both read and write at grant time.
    always_ff @(posedge clk_i) begin
        if (w_dgrant) begin
            assert (!(dmem_r_v_i && dmem_w_v_i))
                else $error("rvga_mem_arbiter: dmem read and write both asserted");
        end
    end

    assign mem_r_v_o  = r_mem_r_v;
    assign mem_w_v_o  = r_mem_w_v;
    assign mem_addr_o = r_mem_addr;
    assign mem_data_o = r_mem_data;

    assign imem_resp_v_o = (r_state == ST_IBUSY) && mem_resp_v_i;
    assign dmem_resp_v_o = (r_state == ST_DBUSY) && mem_resp_v_i;
    assign imem_data_o   = mem_data_i;
    assign dmem_data_o   = mem_data_i;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Directed bench for rvga_mem_arbiter with the bench acting as the memory.
module tb_rvga_mem_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic        imem_r_v_i;
    logic [31:0] imem_addr_i;
    logic [31:0] imem_data_o;
    logic        imem_resp_v_o;
    logic        dmem_r_v_i;
    logic        dmem_w_v_i;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_data_i;
    logic [31:0] dmem_data_o;
    logic        dmem_resp_v_o;
    logic        mem_r_v_o;
    logic        mem_w_v_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_resp_v_i;

    int checks   = 0;
    int failures = 0;

    rvga_mem_arbiter #(
        .WORD_W      (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imem_r_v_i   (imem_r_v_i),
        .imem_addr_i  (imem_addr_i),
        .imem_data_o  (imem_data_o),
        .imem_resp_v_o(imem_resp_v_o),
        .dmem_r_v_i   (dmem_r_v_i),
        .dmem_w_v_i   (dmem_w_v_i),
        .dmem_addr_i  (dmem_addr_i),
        .dmem_data_i  (dmem_data_i),
        .dmem_data_o  (dmem_data_o),
        .dmem_resp_v_o(dmem_resp_v_o),
        .mem_r_v_o    (mem_r_v_o),
        .mem_w_v_o    (mem_w_v_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_resp_v_i (mem_resp_v_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b0;
        imem_r_v_i  = 1'b0;
        imem_addr_i = '0;
        dmem_r_v_i  = 1'b0;
        dmem_w_v_i  = 1'b0;
        dmem_addr_i = '0;
        dmem_data_i = '0;
        mem_data_i  = '0;
        mem_resp_v_i = 1'b0;
        tick();
        tick();
        chk("rst_mem_r_v", 32'(mem_r_v_o), 32'd0);
        chk("rst_mem_w_v", 32'(mem_w_v_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_data", mem_data_o, 32'd0);
        chk("rst_imem_resp", 32'(imem_resp_v_o), 32'd0);
        chk("rst_dmem_resp", 32'(dmem_resp_v_o), 32'd0);
        rst_i = 1'b1;
        tick();

        // Imem only, response two cycles after the strobe.
        imem_r_v_i  = 1'b1;
        imem_addr_i = 32'h40;
        #1;
        chk("a_idle_no_strobe", 32'(mem_r_v_o), 32'd0);
        tick();
        chk("a_strobe1", 32'(mem_r_v_o), 32'd1);
        chk("a_w_low", 32'(mem_w_v_o), 32'd0);
        chk("a_addr", mem_addr_o, 32'h40);
        chk("a_no_resp_early", 32'(imem_resp_v_o), 32'd0);
        tick();
        chk("a_strobe2", 32'(mem_r_v_o), 32'd1);
        tick();
        mem_resp_v_i = 1'b1;
        mem_data_i   = 32'h0050_0093;
        #1;
        chk("a_strobe3", 32'(mem_r_v_o), 32'd1);
        chk("a_imem_resp", 32'(imem_resp_v_o), 32'd1);
        chk("a_imem_data", imem_data_o, 32'h0050_0093);
        chk("a_no_dmem_resp", 32'(dmem_resp_v_o), 32'd0);
        tick();
        mem_resp_v_i = 1'b0;
        #1;
        chk("a_gap_strobe", 32'(mem_r_v_o), 32'd0);
        chk("a_gap_resp", 32'(imem_resp_v_o), 32'd0);
        tick();
        chk("a_idle_strobe", 32'(mem_r_v_o), 32'd0);
        tick();
        chk("a_regrant", 32'(mem_r_v_o), 32'd1);
        mem_resp_v_i = 1'b1;
        #1;
        chk("a_regrant_resp", 32'(imem_resp_v_o), 32'd1);
        tick();
        mem_resp_v_i = 1'b0;
        imem_r_v_i   = 1'b0;
        tick();

        // Simultaneous imem 0x44 and dmem read 0x200: data first.
        imem_r_v_i  = 1'b1;
        imem_addr_i = 32'h44;
        dmem_r_v_i  = 1'b1;
        dmem_addr_i = 32'h200;
        tick();
        chk("b_d_strobe", 32'(mem_r_v_o), 32'd1);
        chk("b_d_addr", mem_addr_o, 32'h200);
        chk("b_d_w_low", 32'(mem_w_v_o), 32'd0);
        mem_resp_v_i = 1'b1;
        mem_data_i   = 32'h1234_5678;
        #1;
        chk("b_dmem_resp", 32'(dmem_resp_v_o), 32'd1);
        chk("b_dmem_data", dmem_data_o, 32'h1234_5678);
        chk("b_no_imem_resp", 32'(imem_resp_v_o), 32'd0);
        tick();
        mem_resp_v_i = 1'b0;
        dmem_r_v_i   = 1'b0;
        #1;
        chk("b_gap_strobe", 32'(mem_r_v_o), 32'd0);
        tick();
        chk("b_idle_strobe", 32'(mem_r_v_o), 32'd0);
        tick();
        chk("b_i_strobe", 32'(mem_r_v_o), 32'd1);
        chk("b_i_addr", mem_addr_o, 32'h44);
        mem_resp_v_i = 1'b1;
        mem_data_i   = 32'hAAAA_0001;
        #1;
        chk("b_imem_resp", 32'(imem_resp_v_o), 32'd1);
        chk("b_imem_data", imem_data_o, 32'hAAAA_0001);
        tick();
        mem_resp_v_i = 1'b0;
        imem_r_v_i   = 1'b0;
        tick();

        // Dmem write 0x300 / 0xDEADBEEF, latched values held until response.
        dmem_w_v_i  = 1'b1;
        dmem_addr_i = 32'h300;
        dmem_data_i = 32'hDEAD_BEEF;
        tick();
        chk("c_w_strobe", 32'(mem_w_v_o), 32'd1);
        chk("c_r_low", 32'(mem_r_v_o), 32'd0);
        chk("c_addr", mem_addr_o, 32'h300);
        chk("c_data", mem_data_o, 32'hDEAD_BEEF);
        dmem_addr_i = 32'h0;
        dmem_data_i = 32'h0;
        tick();
        chk("c_data_held", mem_data_o, 32'hDEAD_BEEF);
        chk("c_addr_held", mem_addr_o, 32'h300);
        chk("c_w_held", 32'(mem_w_v_o), 32'd1);
        chk("c_no_resp_yet", 32'(dmem_resp_v_o), 32'd0);
        mem_resp_v_i = 1'b1;
        #1;
        chk("c_dmem_resp", 32'(dmem_resp_v_o), 32'd1);
        tick();
        mem_resp_v_i = 1'b0;
        dmem_w_v_i   = 1'b0;
        #1;
        chk("c_w_cleared", 32'(mem_w_v_o), 32'd0);
        chk("c_resp_once", 32'(dmem_resp_v_o), 32'd0);
        tick();

        // Starvation: both held, expect 4 data grants then 1 fetch, repeating.
        imem_r_v_i  = 1'b1;
        imem_addr_i = 32'h80;
        dmem_r_v_i  = 1'b1;
        dmem_addr_i = 32'h400;
        for (int g = 0; g < 10; g++) begin
            tick();
            chk($sformatf("d_strobe_%0d", g), 32'(mem_r_v_o), 32'd1);
            chk($sformatf("d_addr_%0d", g), mem_addr_o, ((g % 5) == 4) ? 32'h80 : 32'h400);
            mem_resp_v_i = 1'b1;
            #1;
            chk($sformatf("d_iresp_%0d", g), 32'(imem_resp_v_o),
                ((g % 5) == 4) ? 32'd1 : 32'd0);
            chk($sformatf("d_dresp_%0d", g), 32'(dmem_resp_v_o),
                ((g % 5) == 4) ? 32'd0 : 32'd1);
            tick();
            mem_resp_v_i = 1'b0;
            tick();
        end
        imem_r_v_i = 1'b0;
        dmem_r_v_i = 1'b0;
        tick();

        // Requester drops the read after grant; transaction still completes.
        dmem_r_v_i  = 1'b1;
        dmem_addr_i = 32'h500;
        tick();
        dmem_r_v_i = 1'b0;
        #1;
        chk("e_strobe", 32'(mem_r_v_o), 32'd1);
        tick();
        chk("e_strobe_held", 32'(mem_r_v_o), 32'd1);
        chk("e_addr_held", mem_addr_o, 32'h500);
        mem_resp_v_i = 1'b1;
        mem_data_i   = 32'h0000_0055;
        #1;
        chk("e_dmem_resp", 32'(dmem_resp_v_o), 32'd1);
        chk("e_dmem_data", dmem_data_o, 32'h0000_0055);
        tick();
        mem_resp_v_i = 1'b0;
        #1;
        chk("e_gap_resp", 32'(dmem_resp_v_o), 32'd0);
        chk("e_gap_strobe", 32'(mem_r_v_o), 32'd0);
        tick();
        mem_resp_v_i = 1'b1;
        #1;
        chk("e_spur_dresp", 32'(dmem_resp_v_o), 32'd0);
        chk("e_spur_iresp", 32'(imem_resp_v_o), 32'd0);
        tick();
        mem_resp_v_i = 1'b0;
        #1;
        chk("e_spur_no_strobe", 32'(mem_r_v_o), 32'd0);
        tick();

        // Reset asserted in the middle of a pending write to 0x100.
        dmem_w_v_i  = 1'b1;
        dmem_addr_i = 32'h100;
        dmem_data_i = 32'hCAFE_F00D;
        tick();
        chk("f_w_strobe", 32'(mem_w_v_o), 32'd1);
        chk("f_addr", mem_addr_o, 32'h100);
        rst_i = 1'b0;
        #1;
        chk("f_rst_w", 32'(mem_w_v_o), 32'd0);
        chk("f_rst_r", 32'(mem_r_v_o), 32'd0);
        chk("f_rst_addr", mem_addr_o, 32'd0);
        chk("f_rst_data", mem_data_o, 32'd0);
        chk("f_rst_dresp", 32'(dmem_resp_v_o), 32'd0);
        dmem_w_v_i = 1'b0;
        tick();
        rst_i = 1'b1;
        mem_resp_v_i = 1'b1;
        #1;
        chk("f_post_dresp", 32'(dmem_resp_v_o), 32'd0);
        chk("f_post_iresp", 32'(imem_resp_v_o), 32'd0);
        tick();
        mem_resp_v_i = 1'b0;
        #1;
        chk("f_post_w", 32'(mem_w_v_o), 32'd0);
        chk("f_post_r", 32'(mem_r_v_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
